// File: rtl/ccta_pkg.sv
// Shared constants and FSM state encoding for the CCTA arbiter.
// Imported by ccta_rr_arb and ccta_arbiter.
package ccta_pkg;

    localparam int CCTA_W   = 4;
    localparam int CCTA_QW  = 5;
    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/ccta_rr_arb.sv
// Two-way round-robin decision: picks a winner from two requests
// given which requester was served last.
module ccta_rr_arb
    import ccta_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic winner_o,
    output logic valid_o
);

    logic tie;

    assign tie      = req0_i & req1_i;
    assign valid_o  = req0_i | req1_i;
    assign winner_o = tie ? ~last_i : req1_i;

endmodule

// File: rtl/ccta_arbiter.sv
// Arbitrates two requesters onto one shared CCTA datapath.
// Optional per-requester grant counters with CCTA_ARBITER_STATS_EN.
module ccta_arbiter
    import ccta_pkg::*;
#(
    parameter int HOLD_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0,
    input  logic               req1,
    input  logic [CCTA_W-1:0]  op0_a,
    input  logic [CCTA_W-1:0]  op0_b,
    input  logic [CCTA_W-1:0]  op0_c,
    input  logic               op0_ctrl,
    input  logic [CCTA_W-1:0]  op1_a,
    input  logic [CCTA_W-1:0]  op1_b,
    input  logic [CCTA_W-1:0]  op1_c,
    input  logic               op1_ctrl,
    output logic               gnt0,
    output logic               gnt1,
    output logic               done0,
    output logic               done1,
    output logic [CCTA_QW-1:0] result,
    output logic [CCTA_W-1:0]  ccta_a,
    output logic [CCTA_W-1:0]  ccta_b,
    output logic [CCTA_W-1:0]  ccta_c,
    output logic               ccta_ctrl,
    output logic               ccta_rst,
    input  logic [CCTA_QW-1:0] ccta_q
`ifdef CCTA_ARBITER_STATS_EN
    ,
    output logic [7:0]         stat_cnt0,
    output logic [7:0]         stat_cnt1
`endif
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 last_q;
    logic                 who_q;
    logic                 gnt0_q;
    logic                 gnt1_q;
    logic                 done0_q;
    logic                 done1_q;
    logic                 crst_q;
    logic [CCTA_QW-1:0]   result_q;
    logic [CCTA_W-1:0]    a_q;
    logic [CCTA_W-1:0]    b_q;
    logic [CCTA_W-1:0]    c_q;
    logic                 ctrl_q;

    logic                 win;
    logic                 arb_valid;
    logic                 grant;

    ccta_rr_arb u_rr (
        .req0_i   (req0),
        .req1_i   (req1),
        .last_i   (last_q),
        .winner_o (win),
        .valid_o  (arb_valid)
    );

    assign grant = (state_q == IDLE) && arb_valid;

    // Result is captured on the HOLD exit edge while the datapath is
    // still out of reset; done follows one cycle later from DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            who_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            crst_q   <= 1'b1;
            result_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            ctrl_q   <= 1'b0;
        end else begin
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        who_q   <= win;
                        last_q  <= win;
                        gnt0_q  <= ~win;
                        gnt1_q  <= win;
                        a_q     <= win ? op1_a : op0_a;
                        b_q     <= win ? op1_b : op0_b;
                        c_q     <= win ? op1_c : op0_c;
                        ctrl_q  <= win ? op1_ctrl : op0_ctrl;
                        cnt_q   <= HOLD_LOAD;
                        crst_q  <= 1'b0;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        result_q <= ccta_q;
                        crst_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    done0_q <= ~who_q;
                    done1_q <= who_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign result    = result_q;
    assign ccta_a    = a_q;
    assign ccta_b    = b_q;
    assign ccta_c    = c_q;
    assign ccta_ctrl = ctrl_q;
    assign ccta_rst  = crst_q;

`ifdef CCTA_ARBITER_STATS_EN
    logic [7:0] st0_q;
    logic [7:0] st1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st0_q <= '0;
            st1_q <= '0;
        end else if (grant) begin
            if (!win && st0_q != 8'hFF) st0_q <= st0_q + 8'd1;
            if (win && st1_q != 8'hFF) st1_q <= st1_q + 8'd1;
        end
    end

    assign stat_cnt0 = st0_q;
    assign stat_cnt1 = st1_q;
`endif

endmodule

// File: tb/tb_ccta_arbiter.sv
// Bench for ccta_arbiter: HOLD_CYCLES=1 and =3 instances against a
// transaction-schedule model. Stats checks with CCTA_ARBITER_STATS_EN.
module tb_ccta_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic [3:0] op0_a = '0, op0_b = '0, op0_c = '0;
    logic [3:0] op1_a = '0, op1_b = '0, op1_c = '0;
    logic op0_ctrl = 1'b0, op1_ctrl = 1'b0;

    logic       gnt0[2], gnt1[2], done0[2], done1[2];
    logic [4:0] result[2];
    logic [3:0] ca[2], cb[2], cc[2];
    logic       cctrl[2], crst[2];
    logic [4:0] q[2];
    logic [7:0] s0[2], s1[2];

    int checks = 0;
    int errors = 0;
    int n = 0;

    always #5 clk = ~clk;

    // Behavioural CCTA: zero while held in reset.
    function automatic logic [4:0] f(logic [3:0] a, logic [3:0] b,
                                     logic [3:0] c, logic ctrl);
        int v;
        if (ctrl) v = int'(a ^ b) + int'(c);
        else      v = int'(a) + int'(b) + 5 * int'(c);
        return 5'(v);
    endfunction

    assign q[0] = crst[0] ? 5'd0 : f(ca[0], cb[0], cc[0], cctrl[0]);
    assign q[1] = crst[1] ? 5'd0 : f(ca[1], cb[1], cc[1], cctrl[1]);

    ccta_arbiter #(.HOLD_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .op0_a(op0_a), .op0_b(op0_b), .op0_c(op0_c), .op0_ctrl(op0_ctrl),
        .op1_a(op1_a), .op1_b(op1_b), .op1_c(op1_c), .op1_ctrl(op1_ctrl),
        .gnt0(gnt0[0]), .gnt1(gnt1[0]), .done0(done0[0]), .done1(done1[0]),
        .result(result[0]), .ccta_a(ca[0]), .ccta_b(cb[0]), .ccta_c(cc[0]),
        .ccta_ctrl(cctrl[0]), .ccta_rst(crst[0]), .ccta_q(q[0])
`ifdef CCTA_ARBITER_STATS_EN
        , .stat_cnt0(s0[0]), .stat_cnt1(s1[0])
`endif
    );

    ccta_arbiter #(.HOLD_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .op0_a(op0_a), .op0_b(op0_b), .op0_c(op0_c), .op0_ctrl(op0_ctrl),
        .op1_a(op1_a), .op1_b(op1_b), .op1_c(op1_c), .op1_ctrl(op1_ctrl),
        .gnt0(gnt0[1]), .gnt1(gnt1[1]), .done0(done0[1]), .done1(done1[1]),
        .result(result[1]), .ccta_a(ca[1]), .ccta_b(cb[1]), .ccta_c(cc[1]),
        .ccta_ctrl(cctrl[1]), .ccta_rst(crst[1]), .ccta_q(q[1])
`ifdef CCTA_ARBITER_STATS_EN
        , .stat_cnt0(s0[1]), .stat_cnt1(s1[1])
`endif
    );

`ifndef CCTA_ARBITER_STATS_EN
    assign s0[0] = '0;
    assign s0[1] = '0;
    assign s1[0] = '0;
    assign s1[1] = '0;
`endif

    // Model: each transaction is a start edge plus a fixed schedule.
    int         hk[2] = '{1, 3};
    bit         act[2], who[2], last[2];
    int         st[2];
    logic [3:0] ea[2], eb[2], ec[2];
    logic       ectrl[2];
    logic [4:0] eres[2], pres[2];
    int         sc0[2], sc1[2];

    task automatic chk(string tag, int k, logic [31:0] obs,
                       logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s inst%0d obs=%0h exp=%0h n=%0d",
                   tag, k, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            act[k] = 0; last[k] = 1; who[k] = 0;
            ea[k] = '0; eb[k] = '0; ec[k] = '0; ectrl[k] = 0;
            eres[k] = '0; pres[k] = '0;
            sc0[k] = 0; sc1[k] = 0;
        end
    endtask

    task automatic model_edge();
        bit w;
        for (int k = 0; k < 2; k++) begin
            if (act[k] && n == st[k] + hk[k]) eres[k] = pres[k];
            if (!act[k] || n >= st[k] + hk[k] + 2) begin
                act[k] = 0;
                if (req0 || req1) begin
                    w = (req0 && req1) ? !last[k] : req1;
                    who[k] = w; last[k] = w;
                    ea[k] = w ? op1_a : op0_a;
                    eb[k] = w ? op1_b : op0_b;
                    ec[k] = w ? op1_c : op0_c;
                    ectrl[k] = w ? op1_ctrl : op0_ctrl;
                    pres[k] = f(ea[k], eb[k], ec[k], ectrl[k]);
                    st[k] = n; act[k] = 1;
                    if (!w && sc0[k] < 255) sc0[k]++;
                    if (w && sc1[k] < 255) sc1[k]++;
                end
            end
        end
    endtask

    task automatic compare();
        bit g, d, hold;
        for (int k = 0; k < 2; k++) begin
            g = act[k] && n == st[k];
            d = act[k] && n == st[k] + hk[k] + 1;
            hold = act[k] && n >= st[k] && n <= st[k] + hk[k] - 1;
            chk("gnt0", k, 32'(gnt0[k]), 32'(g && !who[k]));
            chk("gnt1", k, 32'(gnt1[k]), 32'(g && who[k]));
            chk("done0", k, 32'(done0[k]), 32'(d && !who[k]));
            chk("done1", k, 32'(done1[k]), 32'(d && who[k]));
            chk("ccta_rst", k, 32'(crst[k]), 32'(!hold));
            chk("ccta_a", k, 32'(ca[k]), 32'(ea[k]));
            chk("ccta_b", k, 32'(cb[k]), 32'(eb[k]));
            chk("ccta_c", k, 32'(cc[k]), 32'(ec[k]));
            chk("ccta_ctrl", k, 32'(cctrl[k]), 32'(ectrl[k]));
            chk("result", k, 32'(result[k]), 32'(eres[k]));
            chk("gnt_done_overlap", k,
                32'((gnt0[k] | gnt1[k]) & (done0[k] | done1[k])), 32'(0));
`ifdef CCTA_ARBITER_STATS_EN
            chk("stat_cnt0", k, 32'(s0[k]), 32'(sc0[k]));
            chk("stat_cnt1", k, 32'(s1[k]), 32'(sc1[k]));
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        n++;
        model_edge();
        #1;
        compare();
    endtask

    // Called 1 time unit after a rising edge; reset lands mid-cycle.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        chk("rst_ccta_rst", 0, 32'(crst[0]), 32'(1));
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_ops();
        op0_a = 4'($urandom); op0_b = 4'($urandom);
        op0_c = 4'($urandom); op0_ctrl = 1'($urandom);
        op1_a = 4'($urandom); op1_b = 4'($urandom);
        op1_c = 4'($urandom); op1_ctrl = 1'($urandom);
    endtask

    int lat;

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #2;
        compare();
        #1 rst_n = 1'b1;

        // Single request, operands A/6/1/0 -> CCTA returns 5'h15.
        req0 = 1; op0_a = 4'hA; op0_b = 4'h6; op0_c = 4'h1; op0_ctrl = 0;
        step();
        chk("single_gnt0", 0, 32'(gnt0[0]), 32'(1));
        chk("single_a", 0, 32'(ca[0]), 32'(4'hA));
        chk("single_rst", 0, 32'(crst[0]), 32'(0));
        req0 = 0;
        step();
        step();
        chk("single_done0", 0, 32'(done0[0]), 32'(1));
        chk("single_result", 0, 32'(result[0]), 32'(5'h15));
        step();
        step();
        chk("single_done0", 1, 32'(done0[1]), 32'(1));
        chk("single_result", 1, 32'(result[1]), 32'(5'h15));

        // Tie held continuously: grants alternate starting with 0.
        do_reset();
        req0 = 1; req1 = 1;
        for (int i = 0; i < 30; i++) begin
            rand_ops();
            step();
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 6; i++) step();

        // HOLD_CYCLES=3 latency from gnt1 to done1.
        do_reset();
        req1 = 1; rand_ops();
        step();
        chk("lat_gnt1", 1, 32'(gnt1[1]), 32'(1));
        req1 = 0;
        lat = 0;
        do begin
            step();
            lat++;
        end while (!done1[1] && lat < 10);
        chk("lat_done1", 1, 32'(lat), 32'(4));

        // Abort: reset during HOLD yields no done, result stays 0.
        do_reset();
        req0 = 1; rand_ops();
        step();
        req0 = 0;
        step();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        chk("abort_result", 1, 32'(result[1]), 32'(0));
        req0 = 1; rand_ops();
        step();
        req0 = 0;
        for (int i = 0; i < 6; i++) step();
        chk("abort_resume", 1, 32'(result[1]),
            32'(f(op0_a, op0_b, op0_c, op0_ctrl)));

        // Randomised traffic with occasional mid-cycle resets.
        for (int i = 0; i < 400; i++) begin
            req0 = ($urandom_range(0, 3) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            rand_ops();
            if ($urandom_range(0, 99) == 0) do_reset();
            step();
        end
        req0 = 0; req1 = 0;
        for (int i = 0; i < 6; i++) step();

`ifdef CCTA_ARBITER_STATS_EN
        do_reset();
        req0 = 1; req1 = 0;
        for (int i = 0; i < 905; i++) step();
        req0 = 0;
        for (int i = 0; i < 4; i++) step();
        chk("stats_sat0", 0, 32'(s0[0]), 32'(255));
        chk("stats_zero1", 0, 32'(s1[0]), 32'(0));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
